axi_lite_master: RTL

Single-outstanding AXI4-Lite initiator that converts a simple command/response handshake into AXI4-Lite read and write transactions. It sits between a test sequencer or control FSM and AXI4-Lite responders such as the team's `axi_lite_memory`, with identical parameters and AXI port naming so the two connect port-for-port.

---
 rtl/axil_pkg.sv | 23 ++
 rtl/axil_timeout_counter.sv | 28 ++
 rtl/axi_lite_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite initiator: FSM states,
// AXI response codes and default parameter values.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axil_state_e;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

  localparam int AXIL_DATA_WIDTH_DEF     = 32;
  localparam int AXIL_ADDR_WIDTH_DEF     = 4;
  localparam int AXIL_TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/axil_timeout_counter.sv
// Wait-cycle counter for the AXI4-Lite initiator's debug timeout.
// Only instantiated when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_timeout_counter #(
  parameter int LIMIT = 256
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;

  // Expired flags the LIMIT-th counted cycle so the exit edge lands on it.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a cmd/rsp handshake.
// Optional debug timeout recovery is compiled in with AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axil_pkg::*;
#(
  parameter int AXIL_DATA_WIDTH = AXIL_DATA_WIDTH_DEF,
  parameter int AXIL_ADDR_WIDTH = AXIL_ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES  = AXIL_TIMEOUT_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_we,
  output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         rsp_timeout,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [AXIL_ADDR_WIDTH-1:0]   awaddr,
  output logic                         wvalid,
  input  logic                         wready,
  output logic [AXIL_DATA_WIDTH-1:0]   wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
  input  logic                         bvalid,
  output logic                         bready,
  input  logic [1:0]                   bresp,
  output logic                         arvalid,
  input  logic                         arready,
  output logic [AXIL_ADDR_WIDTH-1:0]   araddr,
  input  logic                         rvalid,
  output logic                         rready,
  input  logic [AXIL_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                   rresp
);

  axil_state_e r_state;
  axil_state_e w_state_next;

  logic r_awvalid, r_wvalid, r_arvalid;
  logic r_aw_done, r_w_done;
  logic [AXIL_ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
  logic [AXIL_DATA_WIDTH-1:0]   r_wdata, r_rsp_rdata;
  logic [AXIL_DATA_WIDTH/8-1:0] r_wstrb;
  logic                         r_rsp_we;
  logic [1:0]                   r_rsp_resp;

  logic w_accept, w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic w_aw_done, w_w_done, w_expired, w_timeout;

  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign w_aw_hs   = r_awvalid && awready;
  assign w_w_hs    = r_wvalid && wready;
  assign w_ar_hs   = r_arvalid && arready;
  assign w_b_hs    = (r_state == WR_RESP) && bvalid;
  assign w_r_hs    = (r_state == RD_RESP) && rvalid;
  assign w_aw_done = r_aw_done || w_aw_hs;
  assign w_w_done  = r_w_done || w_w_hs;
  // A response arriving on the expiry cycle still wins over the timeout.
  assign w_timeout = w_expired && !w_b_hs && !w_r_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_state_next = cmd_we ? WR_REQ : RD_REQ;
      WR_REQ:  if (w_aw_done && w_w_done) w_state_next = WR_RESP;
      WR_RESP: if (bvalid) w_state_next = RSP;
      RD_REQ:  if (w_ar_hs) w_state_next = RD_RESP;
      RD_RESP: if (rvalid) w_state_next = RSP;
      RSP:     if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = RSP;
    end
  end

  always_comb begin
    cmd_ready = 1'b0;
    bready    = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE:    cmd_ready = 1'b1;
      WR_RESP: bready    = 1'b1;
      RD_RESP: rready    = 1'b1;
      RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Each request valid falls independently after its own handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_accept) begin
      r_awvalid <= cmd_we;
      r_wvalid  <= cmd_we;
      r_arvalid <= !cmd_we;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_timeout) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= AXIL_RESP_OKAY;
    end else if (w_accept) begin
      if (cmd_we) begin
        r_awaddr <= cmd_addr;
        r_wdata  <= cmd_wdata;
        r_wstrb  <= cmd_wstrb;
      end else begin
        r_araddr <= cmd_addr;
      end
      r_rsp_we    <= cmd_we;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= AXIL_RESP_OKAY;
    end else if (w_b_hs) begin
      r_rsp_rdata <= '0;
      r_rsp_resp  <= bresp;
    end else if (w_r_hs) begin
      r_rsp_rdata <= rdata;
      r_rsp_resp  <= rresp;
    end else if (w_timeout) begin
      r_rsp_rdata <= '0;
      r_rsp_resp  <= AXIL_RESP_SLVERR;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic w_busy, w_cnt_expired, r_rsp_timeout;

  assign w_busy = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                  (r_state == RD_REQ) || (r_state == RD_RESP);

  axil_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clear  (w_accept),
    .i_enable (w_busy),
    .o_expired(w_cnt_expired)
  );

  assign w_expired = w_busy && w_cnt_expired;

  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = r_rsp_timeout;
`else
  // The limit only matters with the timeout built in.
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_expired        = 1'b0;
  assign rsp_timeout      = 1'b0;
`endif

  assign awvalid   = r_awvalid;
  assign wvalid    = r_wvalid;
  assign arvalid   = r_arvalid;
  assign awaddr    = r_awaddr;
  assign araddr    = r_araddr;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign rsp_we    = r_rsp_we;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

endmodule
